if_fetch: RTL and testbench

//   Instruction-fetch stage: owns the fetch PC, drives the synchronous-read instruction memory, and

---
 rtl/if_fetch.sv | 132 +++++++++++++
 tb/tb_if_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the fetch PC, drives a synchronous-read
// instruction memory and presents {pc, inst, valid} to decode. It applies EX and ID
// redirects and holds the decode instruction steady across load-use stalls.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | reset just released, imem idle, nothing in flight
// FILL  | first RESET_PC read in flight, decode sees a bubble
// RUN   | normal streaming fetch, one instruction per cycle
// HOLD  | decode stalled, instruction captured in r_hold_q is shown
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic        r_valid;
  logic        r_held;
  logic [31:0] r_hold_q;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_id_pc_nxt;
  logic        w_valid_nxt;
  logic        w_held_nxt;
  logic [31:0] w_hold_nxt;

  logic [31:0] w_ex_tgt;
  logic [31:0] w_id_tgt;
  logic [31:0] w_pc_plus4;

  // Targets lose their low two bits; there is no misalignment trap.
  assign w_ex_tgt   = ex_target & WORD_MASK;
  assign w_id_tgt   = id_target & WORD_MASK;
  assign w_pc_plus4 = r_pc + 32'd4;

  // State and datapath registers; reset discards any in-flight fetch at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_id_pc  <= RESET_PC;
      r_valid  <= 1'b0;
      r_held   <= 1'b0;
      r_hold_q <= NOP_INST;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_id_pc  <= w_id_pc_nxt;
      r_valid  <= w_valid_nxt;
      r_held   <= w_held_nxt;
      r_hold_q <= w_hold_nxt;
    end
  end

  // Next-state and next-PC selection: EX redirect > stall > ID redirect > sequential.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_id_pc_nxt = r_id_pc;
    w_valid_nxt = r_valid;
    w_held_nxt  = r_held;
    w_hold_nxt  = r_hold_q;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FILL;
      end
      default: begin
        if (ex_redirect) begin
          // EX wins even over a stall; the ID flush happens downstream.
          w_pc_nxt    = w_ex_tgt;
          w_valid_nxt = 1'b0;
          w_held_nxt  = 1'b0;
          w_state_nxt = S_RUN;
        end else if (stall) begin
          if (r_state == S_RUN) begin
            // Capture the instruction now on the bus; imem keeps re-reading pc.
            w_hold_nxt  = imem_rdata;
            w_held_nxt  = 1'b1;
            w_state_nxt = S_HOLD;
          end else if (r_state == S_FILL) begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_RUN;
          w_held_nxt  = 1'b0;
          if (id_redirect && r_valid) begin
            // The pc+4 fetch already in flight becomes the bubble.
            w_pc_nxt    = w_id_tgt;
            w_valid_nxt = 1'b0;
          end else begin
            w_id_pc_nxt = r_pc;
            w_pc_nxt    = w_pc_plus4;
            w_valid_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  assign imem_en   = (r_state != S_BOOT);
  assign imem_addr = r_pc & WORD_MASK;
  assign id_pc     = r_id_pc;
  assign id_valid  = r_valid;
  assign id_inst   = !r_valid ? NOP_INST : (r_held ? r_hold_q : imem_rdata);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed per-cycle vectors push expected outputs into a
// queue; a monitor on the falling edge pops one entry per cycle and compares.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic        id_redirect = 1'b0;
  logic [31:0] id_target = '0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          step_no;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   step_cnt = 0;

  if_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .id_redirect(id_redirect), .id_target(id_target),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: mem[i] = i, word i at RESET_PC + 4*i.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= (imem_addr - RESET_PC) >> 2;
  end

  task automatic chk(input int n, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", n, name, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.step_no, "imem_en", {31'd0, imem_en}, {31'd0, e.en});
      chk(e.step_no, "imem_addr", imem_addr, e.addr);
      chk(e.step_no, "id_valid", {31'd0, id_valid}, {31'd0, e.valid});
      chk(e.step_no, "id_inst", id_inst, e.inst);
      if (e.valid) chk(e.step_no, "id_pc", id_pc, e.pc);
    end
  end

  // One cycle: drive inputs for this cycle and queue the outputs expected during it.
  task automatic step(input logic r, input logic s, input logic er, input logic [31:0] et,
                      input logic ir, input logic [31:0] it,
                      input logic e_en, input logic [31:0] e_addr, input logic e_v,
                      input logic [31:0] e_pc, input logic [31:0] e_inst);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = r;
    stall       = s;
    ex_redirect = er;
    ex_target   = et;
    id_redirect = ir;
    id_target   = it;
    e.step_no = step_cnt;
    e.en      = e_en;
    e.addr    = e_addr;
    e.valid   = e_v;
    e.pc      = e_pc;
    e.inst    = e_inst;
    exp_q.push_back(e);
    step_cnt++;
  endtask

  initial begin
    // rst s er ex_target     ir id_target     en addr          v pc            inst
    step(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h4000_0000, 0, 32'h0,         NOP_INST);
    step(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h4000_0000, 0, 32'h0,         NOP_INST);
    // release: BOOT cycle, then FILL
    step(1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h4000_0000, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0000, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0004, 1, 32'h4000_0000, 32'h0);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0008, 1, 32'h4000_0004, 32'h1);
    // three stalled cycles at id_pc 4000_0008
    step(1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4000_000C, 1, 32'h4000_0008, 32'h2);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4000_000C, 1, 32'h4000_0008, 32'h2);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4000_000C, 1, 32'h4000_0008, 32'h2);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_000C, 1, 32'h4000_0008, 32'h2);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0010, 1, 32'h4000_000C, 32'h3);
    // ID redirect to 4000_0100
    step(1, 0, 0, 32'h0,         1, 32'h4000_0100, 1, 32'h4000_0014, 1, 32'h4000_0010, 32'h4);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0100, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0104, 1, 32'h4000_0100, 32'h40);
    // stall + EX redirect together: EX wins
    step(1, 1, 1, 32'h4000_0200, 0, 32'h0,        1, 32'h4000_0108, 1, 32'h4000_0104, 32'h41);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0200, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0204, 1, 32'h4000_0200, 32'h80);
    // stall + ID redirect together: redirect ignored
    step(1, 1, 0, 32'h0,         1, 32'h4000_0300, 1, 32'h4000_0208, 1, 32'h4000_0204, 32'h81);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0208, 1, 32'h4000_0204, 32'h81);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_020C, 1, 32'h4000_0208, 32'h82);
    // EX redirect to FFFF_FFFF (low bits dropped) and PC wrap
    step(1, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,        1, 32'h4000_0210, 1, 32'h4000_020C, 32'h83);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h2FFF_FFFF);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0000, 32'h3000_0000);
    // misaligned ID target 4000_0102 lands on 4000_0100
    step(1, 0, 0, 32'h0,         1, 32'h4000_0102, 1, 32'h0000_0008, 1, 32'h0000_0004, 32'h3000_0001);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0100, 0, 32'h0,         NOP_INST);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0104, 1, 32'h4000_0100, 32'h40);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0104, 1, 32'h4000_0100, 32'h40);
    // reset pulse mid-stall, asserted between edges
    step(0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h4000_0000, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h4000_0000, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0000, 0, 32'h0,         NOP_INST);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0004, 1, 32'h4000_0000, 32'h0);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4000_0008, 1, 32'h4000_0004, 32'h1);

    begin : drain
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      checks++;
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
